// File: rtl/seq_multiplier.sv
// Sequential 32x32 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// It works on operand magnitudes and applies a two-step sign fix-up through a shared carry-select adder.

module seq_multiplier_csa32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c_i,
    output logic [31:0] s_o,
    output logic        c_o
);
    logic [16:0] lo_sum;
    logic [16:0] hi_sum0;
    logic [16:0] hi_sum1;

    // Both upper-half sums are computed in parallel. The lower-half carry selects one of them.
    assign lo_sum  = {1'b0, a_i[15:0]} + {1'b0, b_i[15:0]} + 17'(c_i);
    assign hi_sum0 = {1'b0, a_i[31:16]} + {1'b0, b_i[31:16]};
    assign hi_sum1 = {1'b0, a_i[31:16]} + {1'b0, b_i[31:16]} + 17'd1;

    assign s_o = {(lo_sum[16] ? hi_sum1[15:0] : hi_sum0[15:0]), lo_sum[15:0]};
    assign c_o = lo_sum[16] ? hi_sum1[16] : hi_sum0[16];
endmodule

module seq_multiplier (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid_1,
    output logic        o_ready_1,
    input  logic [1:0]  i_mulOp_2,
    input  logic [31:0] i_operand1_32,
    input  logic [31:0] i_operand2_32,
    output logic        o_valid_1,
    input  logic        i_resultReady_1,
    output logic [31:0] o_result_32
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_FIX_LO, S_FIX_HI, S_DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        carry_q, carry_d;

    logic [31:0] add_a, add_b, add_s;
    logic        add_ci, add_co;
    logic        a_signed, b_signed, a_neg, b_neg;

    seq_multiplier_csa32 u_adder (
        .a_i (add_a),
        .b_i (add_b),
        .c_i (add_ci),
        .s_o (add_s),
        .c_o (add_co)
    );

    assign a_signed = (i_mulOp_2 == OP_MULH) || (i_mulOp_2 == OP_MULHSU);
    assign b_signed = (i_mulOp_2 == OP_MULH);
    assign a_neg    = a_signed & i_operand1_32[31];
    assign b_neg    = b_signed & i_operand2_32[31];

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        add_a   = hi_q;
        add_b   = '0;
        add_ci  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_valid_1) begin
                    state_d = S_MUL;
                    op_d    = i_mulOp_2;
                    mcand_d = a_neg ? (~i_operand1_32 + 32'd1) : i_operand1_32;
                    lo_d    = b_neg ? (~i_operand2_32 + 32'd1) : i_operand2_32;
                    neg_d   = a_neg ^ b_neg;
                    hi_d    = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end
            end
            S_MUL: begin
                add_a        = hi_q;
                add_b        = lo_q[0] ? mcand_q : '0;
                {hi_d, lo_d} = {add_co, add_s, lo_q[31:1]};
                cnt_d        = cnt_q + 32'd1;
                if (cnt_q == 32'd31) begin
                    state_d = S_FIX_LO;
                end
            end
            S_FIX_LO: begin
                carry_d = 1'b0;
                if (neg_q) begin
                    add_a   = ~lo_q;
                    add_ci  = 1'b1;
                    lo_d    = add_s;
                    carry_d = add_co;
                end
                state_d = S_FIX_HI;
            end
            S_FIX_HI: begin
                // The carry out of the low-word negation completes the 64-bit two's complement.
                if (neg_q) begin
                    add_a  = ~hi_q;
                    add_ci = carry_q;
                    hi_d   = add_s;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (i_resultReady_1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
        end
    end

    assign o_ready_1   = (state_q == S_IDLE);
    assign o_valid_1   = (state_q == S_DONE);
    assign o_result_32 = (state_q != S_DONE) ? '0 : ((op_q == OP_MUL) ? lo_q : hi_q);
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases, backpressure, mid-operation reset,
// and random operations compared against a 64-bit arithmetic reference model.

module tb_seq_multiplier;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid_1;
    logic        o_ready_1;
    logic [1:0]  i_mulOp_2;
    logic [31:0] i_operand1_32;
    logic [31:0] i_operand2_32;
    logic        o_valid_1;
    logic        i_resultReady_1;
    logic [31:0] o_result_32;

    int n_cmp = 0;
    int n_err = 0;

    seq_multiplier dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid_1       (i_valid_1),
        .o_ready_1       (o_ready_1),
        .i_mulOp_2       (i_mulOp_2),
        .i_operand1_32   (i_operand1_32),
        .i_operand2_32   (i_operand2_32),
        .o_valid_1       (o_valid_1),
        .i_resultReady_1 (i_resultReady_1),
        .o_result_32     (o_result_32)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits according to its signedness, then multiply modulo 2^64.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] ax, bx, p;
        ax = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ax * bx;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic scramble_inputs();
        i_valid_1     = 1'($urandom_range(0, 1));
        i_mulOp_2     = 2'($urandom);
        i_operand1_32 = $urandom;
        i_operand2_32 = $urandom;
    endtask

    // Called at a negedge with the block idle. The task returns at a negedge with the block idle again.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int stall);
        int lat;
        lat = 0;
        check({tag, "/ready_idle"}, 64'(o_ready_1), 64'd1);
        i_valid_1     = 1'b1;
        i_mulOp_2     = op;
        i_operand1_32 = a;
        i_operand2_32 = b;
        @(posedge i_clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge i_clk);
            if (o_valid_1) begin
                lat = n;
                break;
            end
            if (n == 5) begin
                check({tag, "/busy_ready"}, 64'(o_ready_1), 64'd0);
                check({tag, "/busy_result"}, 64'(o_result_32), 64'd0);
            end
            scramble_inputs();
        end
        check({tag, "/latency"}, 64'(lat), 64'd35);
        check({tag, "/result"}, 64'(o_result_32), 64'(exp));
        for (int s = 0; s < stall; s++) begin
            scramble_inputs();
            i_valid_1 = 1'b1;
            @(negedge i_clk);
            check({tag, "/hold_valid"}, 64'(o_valid_1), 64'd1);
            check({tag, "/hold_result"}, 64'(o_result_32), 64'(exp));
            check({tag, "/hold_ready"}, 64'(o_ready_1), 64'd0);
        end
        // Consume with i_valid_1 still high. That request must not be taken in the consume cycle.
        i_valid_1       = 1'b1;
        i_resultReady_1 = 1'b1;
        @(negedge i_clk);
        i_resultReady_1 = 1'b0;
        i_valid_1       = 1'b0;
        check({tag, "/post_ready"}, 64'(o_ready_1), 64'd1);
        check({tag, "/post_valid"}, 64'(o_valid_1), 64'd0);
        check({tag, "/post_result"}, 64'(o_result_32), 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          seen_valid;

        i_rst_n         = 1'b0;
        i_valid_1       = 1'b1;
        i_mulOp_2       = 2'b00;
        i_operand1_32   = 32'd9;
        i_operand2_32   = 32'd9;
        i_resultReady_1 = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset/ready", 64'(o_ready_1), 64'd1);
        check("reset/valid", 64'(o_valid_1), 64'd0);
        check("reset/result", 64'(o_result_32), 64'd0);
        i_valid_1 = 1'b0;
        i_rst_n   = 1'b1;
        @(negedge i_clk);

        do_op("mul_7x6",        2'b00, 32'd7,          32'd6,          32'h0000002A, 5);
        do_op("mulhu_ff",       2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 0);
        do_op("mul_ff",         2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1);
        do_op("mulh_min",       2'b01, 32'h80000000,   32'h80000000,   32'h40000000, 0);
        do_op("mulh_m1x1",      2'b01, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 2);
        do_op("mulh_0xm1",      2'b01, 32'h00000000,   32'hFFFFFFFF,   32'h00000000, 0);
        do_op("mulhsu_ff",      2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 0);
        do_op("mulhsu_2x8",     2'b10, 32'h00000002,   32'h80000000,   32'h00000001, 3);

        // Assert reset in cycle k+10 of a MULH. Expect an immediate return to idle and no result.
        i_valid_1     = 1'b1;
        i_mulOp_2     = 2'b01;
        i_operand1_32 = 32'hDEADBEEF;
        i_operand2_32 = 32'h12345678;
        @(posedge i_clk);
        i_valid_1 = 1'b0;
        repeat (10) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("abort/ready", 64'(o_ready_1), 64'd1);
        check("abort/valid", 64'(o_valid_1), 64'd0);
        i_rst_n    = 1'b1;
        seen_valid = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid_1) seen_valid++;
        end
        check("abort/no_result", 64'(seen_valid), 64'd0);
        do_op("after_abort_3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            if (i % 8 == 0) a = 32'h80000000;
            if (i % 8 == 1) b = 32'h80000000;
            if (i % 8 == 2) a = 32'h0;
            do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_result(op, a, b),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameters: none; operand and result widths are fixed at 32 bits.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of i_clk.
REQ-004 i_valid_1  input  1  request valid; the request is accepted when i_valid_1 and o_ready_1 are both 1.
REQ-005 o_ready_1  output  1  block is idle and can accept a request.
REQ-006 i_mulOp_2  input  2  00 MUL (low word), 01 MULH (signed x signed), 10 MULHSU (signed x unsigned), 11 MULHU (unsigned x unsigned).
REQ-007 i_operand1_32  input  32  multiplicand (rs1).
REQ-008 i_operand2_32  input  32  multiplier (rs2).
REQ-009 o_valid_1  output  1  result valid; held until consumed.
REQ-010 i_resultReady_1  input  1  consumer accepts the result when o_valid_1 and i_resultReady_1 are both 1.
REQ-011 o_result_32  output  32  selected product word.

Function
REQ-012 The block SHALL have states IDLE, MUL, FIX_LO, FIX_HI and DONE.
- o_ready_1 = 1 only in IDLE.
- o_valid_1 = 1 only in DONE.
REQ-013 On accept in IDLE the block SHALL latch op, |operand1|, |operand2| and the negate flag, clear the 32-bit iteration counter and the high product word, and enter MUL.
- operand1 is treated as signed for MULH and MULHSU.
- operand2 is treated as signed for MULH only.
- Negate flag = XOR of the signs of the operands treated as signed.
- MUL is always treated as unsigned; the negate flag is 0.
REQ-014 Magnitude conversion SHALL be two's-complement negation of a negative operand; 0x80000000 yields the unsigned magnitude 0x80000000.
REQ-015 Operand and op inputs SHALL be ignored outside the accept cycle; i_valid_1 SHALL be ignored when o_ready_1 = 0.
REQ-016 Every 32-bit addition in MUL, FIX_LO and FIX_HI SHALL use one shared instance of the team's 32-bit carry-select Adder, with its carry-in and carry-out used as specified below.
REQ-017 Each MUL cycle SHALL perform one shift-add step:
- {c, s} = hi + (lo[0] ? mcand : 0), with carry-in 0.
- {hi, lo} <= {c, s, lo[31:1]}.
- The counter increments.
- After the 32nd step the block enters FIX_LO.
REQ-018 FIX_LO SHALL compute lo <= ~lo + 1 (Adder op2 = 0, carry-in 1) when negate = 1, storing the carry-out; when negate = 0, lo is unchanged and the stored carry = 0.
REQ-019 FIX_HI SHALL compute hi <= ~hi + stored carry when negate = 1, leave hi unchanged otherwise, and then enter DONE.
REQ-020 In DONE, o_result_32 SHALL be lo for MUL and hi for all other ops.
REQ-021 Latency: for an accept at cycle k, o_valid_1 SHALL first be 1 in cycle k+35, independent of operand values.
REQ-022 In DONE, o_valid_1 and o_result_32 SHALL remain stable while i_resultReady_1 = 0.
REQ-023 On the consume handshake the block SHALL return to IDLE, so o_ready_1 = 1 in the next cycle.
- No new request is accepted in the consume cycle.
REQ-024 The result is the exact 64-bit product truncated per REQ-020; a zero product with negate = 1 SHALL give 0.
REQ-025 Outside DONE, o_result_32 SHALL be 0.

Reset
REQ-026 While i_rst_n = 0 at a rising edge, the next state SHALL be IDLE.
- Counter, hi, lo, operand registers and stored carry are cleared.
- Outputs: o_ready_1 = 1, o_valid_1 = 0, o_result_32 = 0.
REQ-027 Reset asserted in any state, including mid-MUL or DONE, SHALL abort the operation with no result produced.
REQ-028 The first request after reset release SHALL complete normally.

Verification
REQ-029 MUL 7 x 6, accepted at cycle k -> o_valid_1 = 0 in cycles k+1..k+34; o_valid_1 = 1 with o_result_32 = 0x0000002A in cycle k+35.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFF; MULH 0 x 0xFFFFFFFF -> 0x00000000.
REQ-032 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHSU 0x00000002 x 0x80000000 -> 0x00000001.
REQ-033 Backpressure: i_resultReady_1 = 0 for 5 cycles in DONE with i_valid_1 = 1 and changing operands -> o_valid_1, o_result_32 stable and o_ready_1 = 0 throughout; after consume, o_ready_1 = 1 in the next cycle.
REQ-034 Reset at cycle k+10 of a MULH -> o_ready_1 = 1 and o_valid_1 = 0 after the reset edge, no result is produced, and a following MUL 3 x 5 returns 0x0000000F after 35 cycles.
